ps2_key_encoder: RTL and testbench

- Receives raw PS/2 keyboard serial frames on device clock/data lines and converts them into the 11-bit toggle-strobed key event word used by the core's keyboard decode block.
- Event word format: {toggle, pressed, extended, code[7:0]}.
- Produces events for cores or test rigs that take keys from a physical PS/2 port instead of the HPS.
- Runs entirely in clk_sys; the PS/2 lines are treated as asynchronous inputs.

---
 rtl/ps2_key_encoder_pkg.sv | 35 +++
 rtl/ps2_key_encoder_if.sv | 32 +++
 rtl/ps2_key_encoder_line_rx.sv | 160 ++++++++++++++++
 rtl/ps2_key_encoder.sv | 89 ++++++++
 tb/tb_ps2_key_encoder.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/ps2_key_encoder_pkg.sv
// ps2_pkg: shared scancode constants, frame FSM encoding and decoder helpers.
// Revision: 1.0
`default_nettype none

package ps2_pkg;

    localparam logic [7:0] PS2_EXT        = 8'hE0;
    localparam logic [7:0] PS2_BRK        = 8'hF0;
    localparam logic [7:0] PS2_PAUSE      = 8'hE1;
    localparam logic [7:0] PS2_ACK        = 8'hFA;
    localparam logic [7:0] PS2_BAT        = 8'hAA;
    localparam logic [7:0] PS2_ECHO       = 8'hEE;
    localparam logic [7:0] PS2_RESEND     = 8'hFE;
    localparam logic [7:0] PS2_OVERRUN_LO = 8'h00;
    localparam logic [7:0] PS2_OVERRUN_HI = 8'hFF;
    localparam logic [7:0] PS2_PAUSE_CODE = 8'h77;

    localparam int PS2_PAUSE_LEN = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        CHECK = 2'd2
    } frame_state_t;

    // Keyboard housekeeping replies carry no key information.
    function automatic logic ps2_is_ignored(input logic [7:0] code);
        return (code == PS2_ACK)        || (code == PS2_BAT)    ||
               (code == PS2_ECHO)       || (code == PS2_RESEND) ||
               (code == PS2_OVERRUN_LO) || (code == PS2_OVERRUN_HI);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_key_encoder_if.sv
// ps2_key_encoder_if: PS/2 line inputs and key event / byte outputs of the encoder.
// Revision: 1.0
`default_nettype none

interface ps2_key_encoder_if;
    logic        ps2_clk;
    logic        ps2_data;
    logic [10:0] ps2_key;
    logic        byte_strobe;
    logic [7:0]  byte_data;
    logic        frame_err;

    modport master (
        output ps2_clk,
        output ps2_data,
        input  ps2_key,
        input  byte_strobe,
        input  byte_data,
        input  frame_err
    );

    modport slave (
        input  ps2_clk,
        input  ps2_data,
        output ps2_key,
        output byte_strobe,
        output byte_data,
        output frame_err
    );
endinterface

`default_nettype wire

// File: rtl/ps2_key_encoder_line_rx.sv
// ps2_line_rx: PS/2 line synchronizer, clock glitch filter, 11-bit frame receiver with timeout.
// Revision: 1.0
`default_nettype none

module ps2_line_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 60000
) (
    input  logic       clk_sys,
    input  logic       I_RESET_N,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_strobe,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int c_FCNT_W = $clog2(FILTER_LEN + 1);
    localparam int c_TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]          r_clk_sync;
    logic [1:0]          r_data_sync;
    logic                r_filt_clk;
    logic [c_FCNT_W-1:0] r_fcnt;
    logic                w_clk_s;
    logic                w_data_s;
    logic                w_mismatch;
    logic                w_flip;
    logic                w_fall;
    logic                w_data_al;

    frame_state_t        r_state;
    frame_state_t        w_next;
    logic [9:0]          r_shift;
    logic [3:0]          r_bitcnt;
    logic [c_TMO_W-1:0]  r_tmo;
    logic [7:0]          r_last_byte;
    logic                w_tmo_hit;
    logic                w_frame_ok;

    always_ff @(posedge clk_sys or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            r_clk_sync  <= 2'b11;
            r_data_sync <= 2'b11;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], ps2_clk};
            r_data_sync <= {r_data_sync[0], ps2_data};
        end
    end

    assign w_clk_s    = r_clk_sync[1];
    assign w_data_s   = r_data_sync[1];
    assign w_mismatch = (w_clk_s != r_filt_clk);
    assign w_flip     = w_mismatch && (r_fcnt == c_FCNT_W'(FILTER_LEN - 1));
    assign w_fall     = w_flip && r_filt_clk;

    always_ff @(posedge clk_sys or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            r_filt_clk <= 1'b1;
            r_fcnt     <= '0;
        end else if (w_flip) begin
            r_filt_clk <= ~r_filt_clk;
            r_fcnt     <= '0;
        end else if (w_mismatch) begin
            r_fcnt     <= r_fcnt + 1'b1;
        end else begin
            r_fcnt     <= '0;
        end
    end

    // Delay data by the filter latency so it is sampled where the raw clock fell.
    generate
        if (FILTER_LEN >= 2) begin : g_dly
            logic [FILTER_LEN-2:0] r_dly;
            always_ff @(posedge clk_sys or negedge I_RESET_N) begin
                if (!I_RESET_N) begin
                    r_dly <= '1;
                end else begin
                    r_dly[0] <= w_data_s;
                    for (int i = 1; i <= FILTER_LEN - 2; i++) begin
                        r_dly[i] <= r_dly[i-1];
                    end
                end
            end
            assign w_data_al = r_dly[FILTER_LEN-2];
        end else begin : g_nodly
            assign w_data_al = w_data_s;
        end
    endgenerate

    assign w_tmo_hit  = (r_state == RECV) && !w_fall &&
                        (r_tmo == c_TMO_W'(TIMEOUT_CYCLES - 1));
    assign w_frame_ok = (^r_shift[8:0]) && r_shift[9];

    always_ff @(posedge clk_sys or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_fall && !w_data_al) w_next = RECV;
            RECV: begin
                if (w_tmo_hit)                          w_next = IDLE;
                else if (w_fall && (r_bitcnt == 4'd10)) w_next = CHECK;
            end
            CHECK:   w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        byte_strobe = 1'b0;
        frame_err   = 1'b0;
        byte_data   = r_last_byte;
        case (r_state)
            IDLE:  frame_err = w_fall && w_data_al;
            RECV:  frame_err = w_tmo_hit;
            CHECK: begin
                if (w_frame_ok) begin
                    byte_strobe = 1'b1;
                    byte_data   = r_shift[7:0];
                end else begin
                    frame_err   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_sys or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            r_shift     <= '0;
            r_bitcnt    <= '0;
            r_tmo       <= '0;
            r_last_byte <= '0;
        end else begin
            if (w_fall || (r_state != RECV)) r_tmo <= '0;
            else                             r_tmo <= r_tmo + 1'b1;

            if ((r_state == IDLE) && w_fall && !w_data_al) begin
                r_bitcnt <= 4'd1;
            end else if ((r_state == RECV) && w_fall) begin
                r_bitcnt <= r_bitcnt + 4'd1;
                r_shift  <= {w_data_al, r_shift[9:1]};
            end

            if ((r_state == CHECK) && w_frame_ok) r_last_byte <= r_shift[7:0];
        end
    end

endmodule

`default_nettype wire

// File: rtl/ps2_key_encoder.sv
// ps2_key_encoder: PS/2 bytes to toggle-strobed {toggle, pressed, extended, code} key events.
// Optional PAUSE-sequence collapsing is enabled with macro PS2_PAUSE_EN. Revision: 1.0
`default_nettype none

module ps2_key_encoder
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 60000
) (
    input  logic               clk_sys,
    input  logic               I_RESET_N,
    ps2_key_encoder_if.slave   bus
);

    logic        w_byte_strobe;
    logic [7:0]  w_byte_data;
    logic        w_frame_err;
    logic [10:0] r_key;
    logic        r_ext;
    logic        r_brk;
`ifdef PS2_PAUSE_EN
    logic [2:0]  r_pause_cnt;
`endif

    ps2_line_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_line_rx (
        .clk_sys     (clk_sys),
        .I_RESET_N   (I_RESET_N),
        .ps2_clk     (bus.ps2_clk),
        .ps2_data    (bus.ps2_data),
        .byte_strobe (w_byte_strobe),
        .byte_data   (w_byte_data),
        .frame_err   (w_frame_err)
    );

    assign bus.byte_strobe = w_byte_strobe;
    assign bus.byte_data   = w_byte_data;
    assign bus.frame_err   = w_frame_err;
    assign bus.ps2_key     = r_key;

    always_ff @(posedge clk_sys or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            r_key       <= '0;
            r_ext       <= 1'b0;
            r_brk       <= 1'b0;
`ifdef PS2_PAUSE_EN
            r_pause_cnt <= '0;
`endif
        end else if (w_frame_err) begin
            r_ext       <= 1'b0;
            r_brk       <= 1'b0;
`ifdef PS2_PAUSE_EN
            r_pause_cnt <= '0;
`endif
        end else if (w_byte_strobe) begin
`ifdef PS2_PAUSE_EN
            // Swallow the rest of the PAUSE sequence and report it once on its last byte.
            if (r_pause_cnt != 3'd0) begin
                r_pause_cnt <= r_pause_cnt - 3'd1;
                if (r_pause_cnt == 3'd1) begin
                    r_key <= {~r_key[10], 1'b1, 1'b1, PS2_PAUSE_CODE};
                end
            end else if (w_byte_data == PS2_PAUSE) begin
                r_pause_cnt <= 3'(PS2_PAUSE_LEN);
                r_ext       <= 1'b0;
                r_brk       <= 1'b0;
            end else
`endif
            if (w_byte_data == PS2_EXT) begin
                r_ext <= 1'b1;
            end else if (w_byte_data == PS2_BRK) begin
                r_brk <= 1'b1;
            end else if (ps2_is_ignored(w_byte_data)) begin
                r_ext <= 1'b0;
                r_brk <= 1'b0;
            end else begin
                r_key <= {~r_key[10], ~r_brk, r_ext, w_byte_data};
                r_ext <= 1'b0;
                r_brk <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ps2_key_encoder.sv
// tb_ps2_key_encoder: directed PS/2 frames with a queued scoreboard of expected bytes, key events and errors.
// Revision: 1.0
`default_nettype none

module tb_ps2_key_encoder;

    localparam int FILT = 8;
    localparam int TMO  = 400;
    localparam int HALF = 20;

    typedef enum int {EV_BYTE, EV_KEY, EV_ERR} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       value;
        int       cyc;
    } ev_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    ev_t  exp_q[$];
    logic [10:0] prev_key = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ps2_key_encoder_if bus();

    ps2_key_encoder #(
        .FILTER_LEN     (FILT),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_sys   (clk),
        .I_RESET_N (rst_n),
        .bus       (bus)
    );

    task automatic check(input string name, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic push(input ev_kind_t k, input int v, input int c = -1);
        ev_t e;
        e.kind  = k;
        e.value = v;
        e.cyc   = c;
        exp_q.push_back(e);
    endtask

    task automatic take(input ev_kind_t k, input int v);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_event: got %s %0h required no event", k.name(), v);
        end else begin
            e = exp_q.pop_front();
            n_vec++;
            if ((k != e.kind) || (v != e.value)) begin
                n_bad++;
                $display("FAIL event: got %s %0h required %s %0h", k.name(), v, e.kind.name(), e.value);
            end
            if (e.cyc >= 0) check("event_cycle", cyc, e.cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.byte_strobe)        take(EV_BYTE, int'(bus.byte_data));
            if (bus.frame_err)          take(EV_ERR, 0);
            if (bus.ps2_key != prev_key) take(EV_KEY, int'(bus.ps2_key));
        end
        prev_key = bus.ps2_key;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ps2_bit(input logic b);
        @(negedge clk);
        bus.ps2_data = b;
        idle(HALF);
        bus.ps2_clk = 1'b0;
        idle(HALF);
        bus.ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic bad_par);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit((~^d) ^ bad_par);
        ps2_bit(1'b1);
        idle(3 * HALF);
    endtask

    task automatic send_pref(input logic [7:0] d);
        push(EV_BYTE, int'(d));
        send_frame(d, 1'b0);
    endtask

    task automatic send_key(input logic [7:0] d, input int key);
        push(EV_BYTE, int'(d));
        push(EV_KEY, key);
        send_frame(d, 1'b0);
    endtask

    initial begin
        int t_fall;
        int final_key;
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        idle(5);
        check("reset_key",       int'(bus.ps2_key),     0);
        check("reset_byte_data", int'(bus.byte_data),   0);
        check("reset_strobe",    int'(bus.byte_strobe), 0);
        check("reset_err",       int'(bus.frame_err),   0);
        rst_n = 1'b1;
        idle(20);

        send_key(8'h1C, 11'h61C);
        send_pref(8'hF0);
        send_key(8'h1C, 11'h01C);
        send_pref(8'hE0);
        send_pref(8'hF0);
        send_key(8'h75, 11'h575);

        // Bad parity must also drop the pending E0.
        send_pref(8'hE0);
        push(EV_ERR, 0);
        send_frame(8'h1C, 1'b1);
        send_key(8'h1B, 11'h21B);

        send_pref(8'hE0);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        @(negedge clk);
        bus.ps2_data = 1'b1;
        idle(HALF);
        bus.ps2_clk = 1'b0;
        t_fall = cyc;
        push(EV_ERR, 0, t_fall + FILT + 1 + TMO);
        idle(HALF);
        bus.ps2_clk = 1'b1;
        idle(TMO + 10 + FILT);
        send_key(8'h2B, 11'h62B);

        // Short clock glitch with data high would be a bad start bit if it got through.
        @(negedge clk);
        bus.ps2_data = 1'b1;
        bus.ps2_clk  = 1'b0;
        idle(2);
        bus.ps2_clk  = 1'b1;
        idle(40);

        push(EV_ERR, 0);
        ps2_bit(1'b1);
        idle(3 * HALF);

        send_pref(8'hF0);
        send_pref(8'hAA);
        send_key(8'h1C, 11'h21C);
        send_key(8'h1C, 11'h61C);

`ifdef PS2_PAUSE_EN
        send_pref(8'hE1);
        send_pref(8'h14);
        send_pref(8'h77);
        send_pref(8'hE1);
        send_pref(8'hF0);
        send_pref(8'h14);
        send_pref(8'hF0);
        send_key(8'h77, 11'h377);
        final_key = 11'h377;
`else
        send_key(8'hE1, 11'h2E1);
        send_key(8'h14, 11'h614);
        send_key(8'h77, 11'h277);
        send_key(8'hE1, 11'h6E1);
        send_pref(8'hF0);
        send_key(8'h14, 11'h014);
        send_pref(8'hF0);
        send_key(8'h77, 11'h477);
        final_key = 11'h477;
`endif

        idle(200);
        check("pending_events", exp_q.size(), 0);
        check("final_key", int'(bus.ps2_key), final_key);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
